// File: rtl/lock_chamber_ctrl_pkg.sv
// Shared definitions for the canal-lock sequencer: state encoding and parameter defaults.
// Also imported by the testbench so both sides agree on encodings.
package lock_chamber_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        OPEN_OUTER = 3'd1,
        FILL       = 3'd2,
        OPEN_INNER = 3'd3,
        DRAIN      = 3'd4
    } lock_state_e;

    localparam int ENTER_CYCLES_DEF   = 8;
    localparam int STEP_CYCLES_DEF    = 4;
    localparam int LEVEL_MAX_DEF      = 15;
    localparam int LEVEL_W_DEF        = 4;
    localparam int PEND_MAX_DEF       = 3;
    localparam int PEND_W_DEF         = 2;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    // Wide enough for the longest interval the step timer is loaded with.
    localparam int TIMER_W = 8;

endpackage

// File: rtl/lock_step_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded interval expires.
// Loading value N gives done in the (N+1)-th cycle after the load edge.
module lock_step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;
    logic         active;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_value;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = active && (count == '0);

endmodule

// File: rtl/lock_chamber_ctrl.sv
// Canal-lock sequencer: gate enables, modelled water level and an arrival queue.
// Optional depart watchdog enabled by defining LOCK_TIMEOUT_EN.
module lock_chamber_ctrl
    import lock_chamber_ctrl_pkg::*;
#(
    parameter int ENTER_CYCLES   = ENTER_CYCLES_DEF,
    parameter int STEP_CYCLES    = STEP_CYCLES_DEF,
    parameter int LEVEL_MAX      = LEVEL_MAX_DEF,
    parameter int LEVEL_W        = LEVEL_W_DEF,
    parameter int PEND_MAX       = PEND_MAX_DEF,
    parameter int PEND_W         = PEND_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arriveSignal,
    input  logic               departSignal,
    output logic               outerGateOpen,
    output logic               innerGateOpen,
    output logic [LEVEL_W-1:0] waterLevel,
    output logic [PEND_W-1:0]  pendingCount,
    output logic               busy,
    output logic               fault,
    output logic [2:0]         dbg_state
);

    lock_state_e          state;
    lock_state_e          state_next;
    logic                 step_done;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic [LEVEL_W-1:0]   level_next;
    logic [PEND_W-1:0]    pend_next;
    logic                 timeout_hit;
    logic                 outer_d;
    logic                 inner_d;
    logic                 busy_d;

    // One timer serves every interval; the states using it are mutually exclusive.
    lock_step_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (step_done)
    );

`ifdef LOCK_TIMEOUT_EN
    // A depart in the expiry cycle is an ordinary departure, not a fault.
    assign timeout_hit = (state == OPEN_INNER) && step_done && !departSignal;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (timeout_hit) begin
            fault <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    // State register plus registered outputs taken from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            outerGateOpen <= 1'b0;
            innerGateOpen <= 1'b0;
            busy          <= 1'b0;
            waterLevel    <= '0;
            pendingCount  <= '0;
        end else begin
            state         <= state_next;
            outerGateOpen <= outer_d;
            innerGateOpen <= inner_d;
            busy          <= busy_d;
            waterLevel    <= level_next;
            pendingCount  <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arriveSignal || (pendingCount != '0)) state_next = OPEN_OUTER;
            end
            OPEN_OUTER: begin
                if (step_done) state_next = FILL;
            end
            FILL: begin
                if (step_done && (level_next == LEVEL_W'(LEVEL_MAX))) state_next = OPEN_INNER;
            end
            OPEN_INNER: begin
                if (departSignal || timeout_hit) state_next = DRAIN;
            end
            DRAIN: begin
                if (step_done && (level_next == '0)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Level, queue and timer control.
    always_comb begin
        level_next = waterLevel;
        if ((state == FILL) && step_done && (waterLevel != LEVEL_W'(LEVEL_MAX))) begin
            level_next = waterLevel + 1'b1;
        end else if ((state == DRAIN) && step_done && (waterLevel != '0)) begin
            level_next = waterLevel - 1'b1;
        end

        pend_next = pendingCount;
        if (state == IDLE) begin
            // A queued start consumes one entry; a concurrent arrival takes its place.
            if ((pendingCount != '0) && !arriveSignal) pend_next = pendingCount - 1'b1;
        end else if (arriveSignal && (pendingCount != PEND_W'(PEND_MAX))) begin
            pend_next = pendingCount + 1'b1;
        end

        timer_load = ((state_next != state) && (state_next != IDLE)) ||
                     (step_done && (state_next == state) &&
                      ((state == FILL) || (state == DRAIN)));

        case (state_next)
            OPEN_OUTER: timer_value = TIMER_W'(ENTER_CYCLES - 1);
            OPEN_INNER: timer_value = TIMER_W'(TIMEOUT_CYCLES - 1);
            default:    timer_value = TIMER_W'(STEP_CYCLES - 1);
        endcase
    end

    always_comb begin
        outer_d = (state_next == OPEN_OUTER);
        inner_d = (state_next == OPEN_INNER);
        busy_d  = (state_next != IDLE);
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Self-checking bench for lock_chamber_ctrl: vector table, directed corner sequences
// and randomized traffic against a phase/elapsed-time reference model.
module tb_lock_chamber_ctrl;
    import lock_chamber_ctrl_pkg::*;

    localparam int ENTER = ENTER_CYCLES_DEF;
    localparam int STEP  = STEP_CYCLES_DEF;
    localparam int LMAX  = LEVEL_MAX_DEF;
    localparam int PMAX  = PEND_MAX_DEF;
    localparam int TOUT  = TIMEOUT_CYCLES_DEF;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       arrive_in;
    logic       depart_in;
    logic       outer_open;
    logic       inner_open;
    logic [3:0] level;
    logic [1:0] pend;
    logic       busy;
    logic       fault;
    logic [2:0] dut_state;

    always #5 clk = ~clk;

    lock_chamber_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .arriveSignal  (arrive_in),
        .departSignal  (depart_in),
        .outerGateOpen (outer_open),
        .innerGateOpen (inner_open),
        .waterLevel    (level),
        .pendingCount  (pend),
        .busy          (busy),
        .fault         (fault),
        .dbg_state     (dut_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] exp_q[$];

    function automatic logic [12:0] pack(input logic o, input logic i, input logic [3:0] l,
                                         input logic [1:0] p, input logic b, input logic f,
                                         input logic [2:0] s);
        return {o, i, l, p, b, f, s};
    endfunction

    function automatic string fmt(input logic [12:0] v);
        return $sformatf("outer=%b inner=%b level=%0d pend=%0d busy=%b fault=%b state=%0d",
                         v[12], v[11], v[10:7], v[6:5], v[4], v[3], v[2:0]);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = pack(outer_open, inner_open, level, pend, busy, fault, dut_state);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got [%s] required [%s]", name, fmt(act), fmt(exp));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cyc(input logic a, input logic d);
        arrive_in = a;
        depart_in = d;
        @(posedge clk);
        #1;
        arrive_in = 1'b0;
        depart_in = 1'b0;
    endtask

    task automatic run(input logic a, input logic d, input int n);
        cyc(a, d);
        for (int i = 1; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        check(name, 13'd0);
    endtask

    // ---------------- reference model ----------------
    // Tracks the phase and cycles elapsed in it; level is derived arithmetically.
    lock_state_e m_ph;
    int          m_t;
    int          m_pend;
    logic        m_fault;

    task automatic model_reset();
        m_ph = IDLE; m_t = 0; m_pend = 0; m_fault = 1'b0;
    endtask

    task automatic model_step(input logic a, input logic d);
        lock_state_e nph;
        nph = m_ph;
        if (m_ph == IDLE) begin
            if (a || m_pend > 0) begin
                nph = OPEN_OUTER;
                if (m_pend > 0 && !a) m_pend = m_pend - 1;
            end
        end else if (a) begin
            m_pend = (m_pend + 1 > PMAX) ? PMAX : m_pend + 1;
        end
        case (m_ph)
            OPEN_OUTER: if (m_t == ENTER - 1) nph = FILL;
            FILL:       if (m_t == STEP * LMAX - 1) nph = OPEN_INNER;
            OPEN_INNER: begin
                if (d) nph = DRAIN;
`ifdef LOCK_TIMEOUT_EN
                else if (m_t == TOUT - 1) begin
                    nph = DRAIN;
                    m_fault = 1'b1;
                end
`endif
            end
            DRAIN:      if (m_t == STEP * LMAX - 1) nph = IDLE;
            default:    ;
        endcase
        m_t  = (nph != m_ph) ? 0 : m_t + 1;
        m_ph = nph;
    endtask

    function automatic logic [12:0] model_expect();
        int lvl;
        case (m_ph)
            FILL:       lvl = m_t / STEP;
            OPEN_INNER: lvl = LMAX;
            DRAIN:      lvl = LMAX - m_t / STEP;
            default:    lvl = 0;
        endcase
        return pack(m_ph == OPEN_OUTER, m_ph == OPEN_INNER, 4'(lvl), 2'(m_pend),
                    m_ph != IDLE, m_fault, m_ph);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        a;
        logic        d;
        int          n;
        logic        o;
        logic        i;
        logic [3:0]  l;
        logic [1:0]  p;
        logic        b;
        lock_state_e s;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #(1ms);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        arrive_in = 1'b0;
        depart_in = 1'b0;

        // Single lock cycle timeline: arrive, 8 entry cycles, 60 fill, depart, 60 drain.
        tbl[0]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 4'd0,  2'd0, 1'b1, OPEN_OUTER};
        tbl[1]  = '{1'b0, 1'b0, 7,  1'b1, 1'b0, 4'd0,  2'd0, 1'b1, OPEN_OUTER};
        tbl[2]  = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 4'd0,  2'd0, 1'b1, FILL};
        tbl[3]  = '{1'b0, 1'b0, 4,  1'b0, 1'b0, 4'd1,  2'd0, 1'b1, FILL};
        tbl[4]  = '{1'b0, 1'b0, 55, 1'b0, 1'b0, 4'd14, 2'd0, 1'b1, FILL};
        tbl[5]  = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 4'd15, 2'd0, 1'b1, OPEN_INNER};
        tbl[6]  = '{1'b0, 1'b0, 20, 1'b0, 1'b1, 4'd15, 2'd0, 1'b1, OPEN_INNER};
        tbl[7]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 4'd15, 2'd0, 1'b1, DRAIN};
        tbl[8]  = '{1'b0, 1'b0, 4,  1'b0, 1'b0, 4'd14, 2'd0, 1'b1, DRAIN};
        tbl[9]  = '{1'b0, 1'b0, 55, 1'b0, 1'b0, 4'd1,  2'd0, 1'b1, DRAIN};
        tbl[10] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 4'd0,  2'd0, 1'b0, IDLE};
        tbl[11] = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 4'd0,  2'd0, 1'b0, IDLE};

        // Reset held with arrive asserted: nothing may start.
        cyc(1'b1, 1'b0);
        check("t1_rst_c0", 13'd0);
        cyc(1'b1, 1'b0);
        check("t1_rst_c1", 13'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        check("t1_idle", 13'd0);

        for (int r = 0; r < 12; r++) begin
            run(tbl[r].a, tbl[r].d, tbl[r].n);
            check($sformatf("t2_row%0d", r),
                  pack(tbl[r].o, tbl[r].i, tbl[r].l, tbl[r].p, tbl[r].b, 1'b0, tbl[r].s));
        end

        // Queue saturation and immediate restart from the queue.
        run(1'b1, 1'b0, 1);
        run(1'b0, 1'b0, 8);
        cyc(1'b1, 1'b0);
        check("t3_arr1", pack(1'b0, 1'b0, 4'd0, 2'd1, 1'b1, 1'b0, FILL));
        cyc(1'b1, 1'b0);
        check("t3_arr2", pack(1'b0, 1'b0, 4'd0, 2'd2, 1'b1, 1'b0, FILL));
        cyc(1'b1, 1'b0);
        check("t3_arr3", pack(1'b0, 1'b0, 4'd0, 2'd3, 1'b1, 1'b0, FILL));
        cyc(1'b1, 1'b0);
        check("t3_arr4_sat", pack(1'b0, 1'b0, 4'd1, 2'd3, 1'b1, 1'b0, FILL));
        run(1'b0, 1'b0, 56);
        check("t3_inner", pack(1'b0, 1'b1, 4'd15, 2'd3, 1'b1, 1'b0, OPEN_INNER));
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 60);
        check("t3_idle_gap", pack(1'b0, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0, IDLE));
        cyc(1'b0, 1'b0);
        check("t3_restart", pack(1'b1, 1'b0, 4'd0, 2'd2, 1'b1, 1'b0, OPEN_OUTER));

        // Same-cycle arrive and depart in OPEN_INNER.
        do_reset("t4_reset");
        run(1'b1, 1'b0, 1);
        run(1'b0, 1'b0, 68);
        check("t4_inner", pack(1'b0, 1'b1, 4'd15, 2'd0, 1'b1, 1'b0, OPEN_INNER));
        cyc(1'b1, 1'b1);
        check("t4_arr_dep", pack(1'b0, 1'b0, 4'd15, 2'd1, 1'b1, 1'b0, DRAIN));

        // Reset mid-FILL at level 7 with a queued arrival.
        do_reset("t5_reset_pre");
        run(1'b1, 1'b0, 1);
        run(1'b0, 1'b0, 8);
        cyc(1'b1, 1'b0);
        run(1'b0, 1'b0, 27);
        check("t5_level7", pack(1'b0, 1'b0, 4'd7, 2'd1, 1'b1, 1'b0, FILL));
        do_reset("t5_reset_mid_fill");

        // Depart watchdog.
        run(1'b1, 1'b0, 1);
        run(1'b0, 1'b0, 68);
        run(1'b0, 1'b0, 63);
        check("t6_inner_t63", pack(1'b0, 1'b1, 4'd15, 2'd0, 1'b1, 1'b0, OPEN_INNER));
        cyc(1'b0, 1'b0);
`ifdef LOCK_TIMEOUT_EN
        check("t6_timeout", pack(1'b0, 1'b0, 4'd15, 2'd0, 1'b1, 1'b1, DRAIN));
        run(1'b0, 1'b0, 60);
        check("t6_fault_sticky", pack(1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, IDLE));
`else
        check("t6_no_timeout", pack(1'b0, 1'b1, 4'd15, 2'd0, 1'b1, 1'b0, OPEN_INNER));
        run(1'b0, 1'b0, 100);
        check("t6_still_waiting", pack(1'b0, 1'b1, 4'd15, 2'd0, 1'b1, 1'b0, OPEN_INNER));
`endif
        do_reset("t6_reset");

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            logic a;
            logic d;
            a = ($urandom_range(0, 119) == 0);
            d = ($urandom_range(0, 7) == 0);
            model_step(a, d);
            exp_q.push_back(model_expect());
            cyc(a, d);
            check($sformatf("random_c%0d", c), exp_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
